// File: rtl/mm_pkg.sv
// Shared types for the mastermind round sequencer.
// State encoding, winner codes and default code length.
package mm_pkg;

  localparam int CODE_LEN_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET,
    S_GUESS,
    S_WAIT,
    S_END,
    S_DONE
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/mm_press_detect.sv
// Button rising-edge detector for both players.
// A press counts only when the other player is not pressing too.
module mm_press_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic enterA,
  input  logic enterB,
  output logic pressA,
  output logic pressB
);

  logic a_q;
  logic b_q;
  logic rise_a;
  logic rise_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      a_q <= enterA;
      b_q <= enterB;
    end
  end

  assign rise_a = enterA & ~a_q;
  assign rise_b = enterB & ~b_q;
  assign pressA = rise_a & ~rise_b;
  assign pressB = rise_b & ~rise_a;

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Round sequencer: alternates setter/guesser, strobes the
// code/guess latches, counts guesses and keeps scores.
module mastermind_round_ctrl
  import mm_pkg::*;
#(
  parameter  int CODE_LEN    = CODE_LEN_DEF,
  parameter  int MAX_GUESSES = 10,
  parameter  int ROUNDS      = 4,
  parameter  int SW          = 8,
  localparam int CW = $clog2(CODE_LEN + 1),
  localparam int GW = $clog2(MAX_GUESSES + 2),
  localparam int RW = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          started,
  input  logic          first_setter_a,
  input  logic          enterA,
  input  logic          enterB,
  input  logic          res_valid,
  input  logic [CW-1:0] res_exact,
  output logic          load_code,
  output logic          load_guess,
  output logic          setter_is_a,
  output logic [GW-1:0] guess_cnt,
  output logic [RW-1:0] round_idx,
  output logic [SW-1:0] score_a,
  output logic [SW-1:0] score_b,
  output logic          round_over,
  output logic          game_over,
  output logic [1:0]    winner
);

  state_t        state_q, state_d;
  logic          setter_d;
  logic [GW-1:0] guess_d;
  logic [RW-1:0] round_d;
  logic [SW-1:0] sa_d, sb_d;
  logic          lc_d, lg_d, ro_d;
  logic [GW-1:0] pts;
  logic          press_a, press_b;
  logic          press_set, press_gss;

  function automatic logic [SW-1:0] sat_add(
    input logic [SW-1:0] a,
    input logic [GW-1:0] b
  );
    logic [SW:0] s;
    s = {1'b0, a} + (SW+1)'(b);
    return s[SW] ? '1 : s[SW-1:0];
  endfunction

  mm_press_detect u_press (
    .clk    (clk),
    .reset_n(reset_n),
    .enterA (enterA),
    .enterB (enterB),
    .pressA (press_a),
    .pressB (press_b)
  );

  assign press_set = setter_is_a ? press_a : press_b;
  assign press_gss = setter_is_a ? press_b : press_a;

  always_comb begin
    state_d  = state_q;
    setter_d = setter_is_a;
    guess_d  = guess_cnt;
    round_d  = round_idx;
    sa_d     = score_a;
    sb_d     = score_b;
    lc_d     = 1'b0;
    lg_d     = 1'b0;
    ro_d     = 1'b0;
    pts      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (started) begin
          setter_d = first_setter_a;
          state_d  = S_SET;
        end
      end
      S_SET: begin
        if (press_set) begin
          lc_d    = 1'b1;
          guess_d = '0;
          state_d = S_GUESS;
        end
      end
      S_GUESS: begin
        if (press_gss) begin
          lg_d    = 1'b1;
          guess_d = guess_cnt + GW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          if (res_exact == CW'(CODE_LEN)) begin
            pts     = guess_cnt;
            state_d = S_END;
          end else if (guess_cnt == GW'(MAX_GUESSES)) begin
            pts     = GW'(MAX_GUESSES + 1);
            state_d = S_END;
          end else begin
            state_d = S_GUESS;
          end
          if (setter_is_a) sa_d = sat_add(score_a, pts);
          else             sb_d = sat_add(score_b, pts);
        end
      end
      S_END: begin
        ro_d     = 1'b1;
        round_d  = round_idx + RW'(1);
        setter_d = ~setter_is_a;
        state_d  = (round_d == RW'(ROUNDS)) ? S_DONE : S_SET;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
    // abandoning a game wipes all progress
    if (!started && state_q != S_DONE) begin
      state_d  = S_IDLE;
      setter_d = 1'b0;
      guess_d  = '0;
      round_d  = '0;
      sa_d     = '0;
      sb_d     = '0;
      lc_d     = 1'b0;
      lg_d     = 1'b0;
      ro_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      setter_is_a <= 1'b0;
      guess_cnt   <= '0;
      round_idx   <= '0;
      score_a     <= '0;
      score_b     <= '0;
      load_code   <= 1'b0;
      load_guess  <= 1'b0;
      round_over  <= 1'b0;
    end else begin
      state_q     <= state_d;
      setter_is_a <= setter_d;
      guess_cnt   <= guess_d;
      round_idx   <= round_d;
      score_a     <= sa_d;
      score_b     <= sb_d;
      load_code   <= lc_d;
      load_guess  <= lg_d;
      round_over  <= ro_d;
    end
  end

  assign game_over = (state_q == S_DONE);

  always_comb begin
    winner = WIN_NONE;
    if (game_over) begin
      if (score_a > score_b)      winner = WIN_A;
      else if (score_b > score_a) winner = WIN_B;
      else                        winner = WIN_TIE;
    end
  end

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Randomized bench for mastermind_round_ctrl against
// a transaction-level game model.
module tb_mastermind_round_ctrl;

  localparam int CODE_LEN = 4;
  localparam int MAXG     = 10;
  localparam int ROUNDS   = 4;
  localparam int SW       = 8;
  localparam int SMAX     = (1 << SW) - 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       started;
  logic       first_setter_a;
  logic       enterA;
  logic       enterB;
  logic       res_valid;
  logic [2:0] res_exact;
  logic       load_code;
  logic       load_guess;
  logic       setter_is_a;
  logic [3:0] guess_cnt;
  logic [2:0] round_idx;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic       round_over;
  logic       game_over;
  logic [1:0] winner;

  mastermind_round_ctrl #(
    .CODE_LEN   (CODE_LEN),
    .MAX_GUESSES(MAXG),
    .ROUNDS     (ROUNDS),
    .SW         (SW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .started       (started),
    .first_setter_a(first_setter_a),
    .enterA        (enterA),
    .enterB        (enterB),
    .res_valid     (res_valid),
    .res_exact     (res_exact),
    .load_code     (load_code),
    .load_guess    (load_guess),
    .setter_is_a   (setter_is_a),
    .guess_cnt     (guess_cnt),
    .round_idx     (round_idx),
    .score_a       (score_a),
    .score_b       (score_b),
    .round_over    (round_over),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // game model: who sets, scores (0 = A, 1 = B), rounds done
  bit m_sa;
  int m_score[2];
  int m_rounds;

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, got, exp);
  endtask

  task automatic do_press(input bit a, input bit b,
                          input bit ec, input bit eg);
    enterA = a;
    enterB = b;
    @(negedge clk);
    enterA = 1'b0;
    enterB = 1'b0;
    chk("load_code", load_code, ec);
    chk("load_guess", load_guess, eg);
    @(negedge clk);
    chk("strobe_width", load_code | load_guess, 0);
  endtask

  task automatic pulse_res(input int e);
    res_valid = 1'b1;
    res_exact = 3'(e);
    @(negedge clk);
    res_valid = 1'b0;
    res_exact = '0;
  endtask

  task automatic chk_scores(input string tag);
    chk({tag, "_a"}, score_a, m_score[0]);
    chk({tag, "_b"}, score_b, m_score[1]);
  endtask

  task automatic start_game(input bit f);
    started        = 1'b1;
    first_setter_a = f;
    @(negedge clk);
    m_sa       = f;
    m_score[0] = 0;
    m_score[1] = 0;
    m_rounds   = 0;
    chk("start_setter", setter_is_a, f);
    chk("start_guess_cnt", guess_cnt, 0);
  endtask

  task automatic play_round(input int n, input bit hit);
    bit s;
    int e;
    int pts;
    int idx;
    s   = m_sa;
    pts = MAXG + 1;
    if ($urandom_range(1) == 1) do_press(!s, s, 0, 0);
    do_press(1, 1, 0, 0);
    if ($urandom_range(1) == 1) begin
      pulse_res(CODE_LEN);
      chk_scores("res_in_set");
    end
    do_press(s, !s, 1, 0);
    chk("guess_cnt_clr", guess_cnt, 0);
    for (int g = 1; g <= MAXG; g++) begin
      if ($urandom_range(2) == 0) do_press(s, !s, 0, 0);
      if ($urandom_range(3) == 0) begin
        pulse_res(CODE_LEN);
        chk_scores("res_in_guess");
      end
      chk("guess_cnt_hold", guess_cnt, g - 1);
      do_press(!s, s, 0, 1);
      chk("guess_cnt", guess_cnt, g);
      if ($urandom_range(2) == 0) do_press(!s, s, 0, 0);
      e = (hit && g == n) ? CODE_LEN
                          : int'($urandom_range(CODE_LEN - 1));
      pulse_res(e);
      if (e == CODE_LEN) begin
        pts = g;
        break;
      end
      if (g != MAXG) chk_scores("score_hold");
    end
    idx = s ? 0 : 1;
    m_score[idx] = m_score[idx] + pts;
    if (m_score[idx] > SMAX) m_score[idx] = SMAX;
    m_rounds++;
    m_sa = !m_sa;
    chk_scores("score");
    chk("round_over_early", round_over, 0);
    @(negedge clk);
    chk("round_over", round_over, 1);
    chk("round_idx", round_idx, m_rounds);
    chk("setter_toggle", setter_is_a, m_sa);
    @(negedge clk);
    chk("round_over_width", round_over, 0);
    chk("game_over", game_over, m_rounds == ROUNDS);
  endtask

  task automatic chk_done();
    int w;
    if (m_score[0] > m_score[1])      w = 1;
    else if (m_score[1] > m_score[0]) w = 2;
    else                              w = 3;
    chk("done_game_over", game_over, 1);
    chk("done_winner", winner, w);
    chk("done_round_idx", round_idx, ROUNDS);
    do_press(1, 0, 0, 0);
    do_press(0, 1, 0, 0);
    pulse_res(CODE_LEN);
    chk_scores("done_hold");
    chk("done_stay", game_over, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_load_code"}, load_code, 0);
    chk({tag, "_load_guess"}, load_guess, 0);
    chk({tag, "_setter"}, setter_is_a, 0);
    chk({tag, "_guess_cnt"}, guess_cnt, 0);
    chk({tag, "_round_idx"}, round_idx, 0);
    chk({tag, "_score_a"}, score_a, 0);
    chk({tag, "_score_b"}, score_b, 0);
    chk({tag, "_round_over"}, round_over, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
  endtask

  task automatic do_reset();
    started = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n        = 1'b0;
    started        = 1'b0;
    first_setter_a = 1'b0;
    enterA         = 1'b0;
    enterB         = 1'b0;
    res_valid      = 1'b0;
    res_exact      = '0;
    repeat (2) @(negedge clk);
    chk_zero("por");
    reset_n = 1'b1;
    @(negedge clk);

    // directed tie game: A 3+2, B 4+1
    start_game(1);
    play_round(3, 1);
    play_round(4, 1);
    play_round(2, 1);
    play_round(1, 1);
    chk_done();
    started = 1'b0;
    @(negedge clk);
    chk("done_ignores_started", game_over, 1);
    do_reset();

    // random game, first round is a full miss
    start_game(1'($urandom_range(1)));
    play_round(MAXG, 0);
    for (int r = 1; r < ROUNDS; r++) begin
      bit h;
      h = ($urandom_range(3) != 0);
      play_round(h ? int'($urandom_range(1, MAXG)) : MAXG, h);
    end
    chk_done();
    do_reset();

    // abandon mid-round, then async reset in WAIT
    start_game(1);
    play_round(3, 1);
    do_press(0, 1, 1, 0);
    do_press(1, 0, 0, 1);
    started = 1'b0;
    @(negedge clk);
    chk("abandon_score_a", score_a, 0);
    chk("abandon_round_idx", round_idx, 0);
    chk("abandon_guess_cnt", guess_cnt, 0);
    start_game(1);
    play_round(3, 1);
    chk("pre_reset_score_a", score_a, 3);
    do_press(0, 1, 1, 0);
    do_press(1, 0, 0, 1);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
